// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU controller: FSM states and the
// operation-select encoding forwarded to the 1-bit slice.
package alu_pkg;

    localparam int OPSEL_W = 3;

    typedef logic [OPSEL_W-1:0] opsel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer for an external combinational 1-bit ALU slice: walks a WIDTH-bit
// operation LSB-first through the slice and returns the assembled result.
module bit_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  opsel_t           in_opsel,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,

    output logic             busy,

    output logic             sl_op1,
    output logic             sl_op2,
    output logic             sl_c_in,
    output opsel_t           sl_opsel,
    input  logic             sl_result,
    input  logic             sl_carry
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q,  carry_d;
    opsel_t           opsel_q,  opsel_d;

    // NOTE: every next-state signal takes its current value first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        opsel_d  = opsel_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SHIFT;
                    a_sh_d   = in_a;
                    b_sh_d   = in_b;
                    carry_d  = in_cin;
                    opsel_d  = in_opsel;
                    cnt_d    = '0;
                    res_sh_d = '0;
                end
            end

            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {sl_result, res_sh_q[WIDTH-1:1]};
                carry_d  = sl_carry;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // The result is held until consumed; a new request can only
                // be taken once back in IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            opsel_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            opsel_q  <= opsel_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        out_result = res_sh_q;
        out_carry  = carry_q;
        sl_opsel   = opsel_q;
        // Slice operands are forced low outside SHIFT.
        sl_op1     = (state_q == SHIFT) & a_sh_q[0];
        sl_op2     = (state_q == SHIFT) & b_sh_q[0];
        sl_c_in    = (state_q == SHIFT) & carry_q;
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Testbench for bit_serial_alu_ctrl with a behavioural full-adder slice;
// expected values come from whole-word arithmetic on the operands.
module tb_bit_serial_alu_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    opsel_t       in_opsel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         busy;
    logic         sl_op1;
    logic         sl_op2;
    logic         sl_c_in;
    opsel_t       sl_opsel;
    logic         sl_result;
    logic         sl_carry;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural full-adder slice.
    assign sl_result = sl_op1 ^ sl_op2 ^ sl_c_in;
    assign sl_carry  = (sl_op1 & sl_op2) | (sl_op1 & sl_c_in) | (sl_op2 & sl_c_in);

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_opsel   (in_opsel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .busy       (busy),
        .sl_op1     (sl_op1),
        .sl_op2     (sl_op2),
        .sl_c_in    (sl_c_in),
        .sl_opsel   (sl_opsel),
        .sl_result  (sl_result),
        .sl_carry   (sl_carry)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Carry entering bit i of a+b+cin, from the sum of the lower i bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input int i);
        int mask;
        int s;
        mask = (1 << i) - 1;
        s    = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
        return logic'((s >> i) & 1);
    endfunction

    // Called at the negedge just after the accept edge; ends at the negedge
    // just after the last SHIFT edge (DONE). Scrambles in_* and in_opsel.
    task automatic shift_phase(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input opsel_t op, input string tag);
        for (int i = 0; i < W; i++) begin
            check({tag, " busy"},     busy,     1);
            check({tag, " in_ready"}, in_ready, 0);
            check({tag, " out_valid"}, out_valid, 0);
            check({tag, " sl_op1"},   sl_op1,   a[i]);
            check({tag, " sl_op2"},   sl_op2,   b[i]);
            check({tag, " sl_c_in"},  sl_c_in,  carry_into(a, b, cin, i));
            check({tag, " sl_opsel"}, sl_opsel, op);
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            in_opsel = opsel_t'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic done_checks(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input opsel_t op, input string tag);
        int s;
        s = int'(a) + int'(b) + int'(cin);
        check({tag, " out_valid"},  out_valid,  1);
        check({tag, " in_ready"},   in_ready,   0);
        check({tag, " out_result"}, out_result, s & 8'hFF);
        check({tag, " out_carry"},  out_carry,  (s >> W) & 1);
        check({tag, " sl_op1 idle"}, {sl_op1, sl_op2, sl_c_in}, 0);
        check({tag, " sl_opsel hold"}, sl_opsel, op);
    endtask

    // Full transaction from IDLE: accept, shift, hold for 'hold' cycles, consume.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input opsel_t op, input int hold,
                          input string tag);
        check({tag, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_opsel = op;
        @(negedge clk);
        in_valid = 1'b0;
        shift_phase(a, b, cin, op, tag);
        for (int h = 0; h < hold; h++) begin
            done_checks(a, b, cin, op, tag);
            @(negedge clk);
        end
        done_checks(a, b, cin, op, tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " back idle"}, {in_ready, out_valid, busy}, 3'b100);
        check({tag, " opsel kept"}, sl_opsel, op);
    endtask

    initial begin
        logic [W-1:0] ra, rb, pa, pb;
        logic         rc, pc;
        opsel_t       ro, po;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_opsel  = '0;
        out_ready = 1'b0;
        #1;
        check("reset ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("reset data", {out_result, out_carry}, 0);
        check("reset slice", {sl_op1, sl_op2, sl_c_in, sl_opsel}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hA5, 8'h3C, 1'b0, 3'b000, 0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 3'b001, 0, "overflow");
        run_op(8'h00, 8'h00, 1'b1, 3'b101, 2, "carry_in");

        // Back-pressure with a pending request that must wait for IDLE.
        ra = 8'h5A; rb = 8'hC3; rc = 1'b1; ro = 3'b011;
        pa = 8'h81; pb = 8'h7F; pc = 1'b0; po = 3'b110;
        in_valid = 1'b1; in_a = ra; in_b = rb; in_cin = rc; in_opsel = ro;
        @(negedge clk);
        in_valid = 1'b0;
        shift_phase(ra, rb, rc, ro, "bp");
        in_valid = 1'b1; in_a = pa; in_b = pb; in_cin = pc; in_opsel = po;
        for (int h = 0; h < 20; h++) begin
            done_checks(ra, rb, rc, ro, "bp hold");
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release idle", {in_ready, out_valid, busy}, 3'b100);
        @(negedge clk);
        in_valid = 1'b0;
        shift_phase(pa, pb, pc, po, "bp pending");
        done_checks(pa, pb, pc, po, "bp pending");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in SHIFT cycle 4: asynchronous clear, no result afterwards.
        in_valid = 1'b1; in_a = 8'h37; in_b = 8'h99; in_cin = 1'b1; in_opsel = 3'b111;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("async rst data", {out_result, out_carry}, 0);
        check("async rst slice", {sl_op1, sl_op2, sl_c_in, sl_opsel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            check("post-reset quiet", {in_ready, out_valid, busy}, 3'b100);
            @(negedge clk);
        end

        // Randomised operations against whole-word arithmetic.
        for (int n = 0; n < 12; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ro = opsel_t'($urandom);
            run_op(ra, rb, rc, ro, int'($urandom_range(0, 3)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Sequencer that drives the combinational 1-bit arithmetic slice, which takes op1/op2/c_in/opsel and returns a result bit and a carry bit. It accepts a WIDTH-bit operation through a valid/ready handshake and presents operand bits to the slice LSB-first, one per clock. Each cycle it captures the slice's result bit and carry bit and returns the carry to the slice on the next cycle. It assembles the WIDTH-bit result and final carry and holds them on an output valid/ready handshake until consumed.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry into bit 0.
- in_opsel  in  3  operation select; forwarded to the slice unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  assembled result.
- out_carry  out  1  carry out of bit WIDTH-1.
- busy  out  1  high while state is not IDLE.
- sl_op1  out  1  slice operand-1 bit.
- sl_op2  out  1  slice operand-2 bit.
- sl_c_in  out  1  slice carry-in bit.
- sl_opsel  out  3  slice operation select.
- sl_result  in  1  slice result bit (combinational from sl_* outputs).
- sl_carry  in  1  slice carry-out bit.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: presents bits to the slice.
  - DONE: out_valid=1.
- IDLE → SHIFT on in_valid & in_ready.
  - Load a_sh=in_a, b_sh=in_b, carry_q=in_cin, opsel_q=in_opsel, cnt=0, res_sh=0.
- SHIFT, every cycle:
  - Drive sl_op1=a_sh[0], sl_op2=b_sh[0], sl_c_in=carry_q.
  - At the clock edge:
    - a_sh, b_sh shift right by one.
    - res_sh = {sl_result, res_sh[WIDTH-1:1]}.
    - carry_q = sl_carry.
    - cnt++.
- SHIFT → DONE at the edge where cnt == WIDTH-1.
- DONE:
  - out_result = res_sh and out_carry = carry_q; both stable while out_valid=1.
  - DONE → IDLE on out_ready.
- sl_opsel = opsel_q in all states; the slice sees a constant opsel for the whole operation.
- In IDLE and DONE: sl_op1 = sl_op2 = sl_c_in = 0.
- in_ready is high only in IDLE. A request presented in DONE waits until IDLE, even if out_ready is high in the same cycle.
- in_* inputs are sampled only on the accept edge; later changes have no effect.
- The slice is combinational. Its result is captured the same cycle; there is no slice pipeline.

## Timing
- Reset (asynchronous, with async deassert): state=IDLE, cnt=0, all shift registers and carry_q=0, opsel_q=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, out_result=0, out_carry=0, all sl_* outputs 0.
- Latency: accept at edge k → out_valid high after edge k+WIDTH.
- Minimum spacing between accepts: WIDTH+2 cycles, when out_ready is held high.
- out_valid stays high indefinitely while out_ready=0. No result is ever dropped or overwritten.
- Reset asserted mid-SHIFT or in DONE: operation discarded, no out_valid pulse, immediately IDLE.
- cnt width is $clog2(WIDTH). Bit index 0 feeds sl_c_in=in_cin; no wrap beyond WIDTH-1.

## Structure
- Shared package alu_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - OPSEL_W=3 constant;
  - opsel typedef logic [OPSEL_W-1:0].
- Single module with no sub-modules. The slice is instantiated by the parent and connected through the sl_* ports.
- Target size 120–200 lines.

## Test plan
All scenarios use WIDTH=8, with sl_result/sl_carry driven by a behavioural full adder: sum = op1^op2^c_in, carry = majority(op1, op2, c_in).
- Basic add: a=8'hA5, b=8'h3C, cin=0 → after 8 cycles out_result=8'hE1, out_carry=0; sl_op1 sequence is 1,0,1,0,0,1,0,1.
- Overflow: a=8'hFF, b=8'h01, cin=0 → out_result=8'h00, out_carry=1.
- Carry in: a=8'h00, b=8'h00, cin=1 → out_result=8'h01, out_carry=0; sl_c_in=1 only in the first SHIFT cycle.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid rises → result stable, in_ready=0 throughout, in_valid ignored. Raise out_ready → next cycle IDLE, then the pending request is accepted.
- Reset mid-operation: assert rst_n=0 at SHIFT cycle 4 → all outputs 0 asynchronously. After release: in_ready=1 and no out_valid pulse.
- Opsel hold: in_opsel=3'b101 at accept, then change in_opsel during SHIFT → sl_opsel stays 3'b101 until the next accept.
